// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding,
// operand width and iteration count.
package mult_pkg;

  localparam int MULT_W    = 32;
  localparam int MULT_ITER = 32;
  localparam int CNT_W     = $clog2(MULT_ITER);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mult_if.sv
// Operand/result bundle of the shift-and-add multiplier; the requester
// uses the master modport, the multiplier the slave modport.
interface shift_add_mult_if;

  logic        ctrl_mult;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRdy;

  modport master (
    output ctrl_mult, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRdy
  );

  modport slave (
    input  ctrl_mult, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRdy
  );

endinterface

// File: rtl/sll_32.sv
// 32-bit logical shift-left stage used to form the per-iteration partial product.
module sll_32 (
  input  logic [31:0] in,
  input  logic [4:0]  shft_amt,
  output logic [31:0] out
);

  assign out = in << shft_amt;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential 32x32 signed shift-and-add multiplier, one multiplier bit per clock.
// Optional signed-overflow detection is enabled by defining MULT_OVF_DETECT_EN.
module shift_add_mult
  import mult_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  shift_add_mult_if.slave bus
);

`ifdef MULT_OVF_DETECT_EN
  localparam int ACC_W = 2 * MULT_W;
`else
  localparam int ACC_W = MULT_W;
`endif

  state_t            state_q, state_d;
  logic [MULT_W-1:0] a_q, a_d;
  logic [MULT_W-1:0] b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MULT_W-1:0] result_q, result_d;
  logic              rdy_q, rdy_d;
  logic [MULT_W-1:0] shifted_lo;
  logic [ACC_W-1:0]  partial;
  logic [ACC_W-1:0]  acc_step;

  sll_32 u_sll_32 (
    .in       (a_q),
    .shft_amt (cnt_q),
    .out      (shifted_lo)
  );

`ifdef MULT_OVF_DETECT_EN
  logic [MULT_W-1:0] shifted_hi;
  logic [32:0]       top_bits;
  logic              ovf;
  logic              exc_q, exc_d;

  // Upper half of the sign-extended multiplicand after the shift: sign fill
  // plus the bits the 32-bit shifter pushed out (none when count is 0).
  assign shifted_hi = ({MULT_W{a_q[MULT_W-1]}} << cnt_q)
                    | (a_q >> (6'd32 - {1'b0, cnt_q}));
  assign partial    = {shifted_hi, shifted_lo};
  assign top_bits   = acc_step[63:31];
  assign ovf        = !((&top_bits) || !(|top_bits));
`else
  assign partial    = shifted_lo;
`endif

  // Bit 31 of the multiplier carries weight -2^31, hence the subtraction.
  assign acc_step = !b_q[cnt_q]          ? acc_q :
                    (cnt_q == LAST_CNT)  ? acc_q - partial :
                                           acc_q + partial;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rdy_d    = 1'b0;
`ifdef MULT_OVF_DETECT_EN
    exc_d    = exc_q;
`endif
    if (bus.ctrl_mult) begin
      state_d = RUN;
      a_d     = bus.data_operandA;
      b_d     = bus.data_operandB;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          acc_d = acc_step;
          if (cnt_q == LAST_CNT) begin
            state_d  = DONE;
            result_d = acc_step[MULT_W-1:0];
            rdy_d    = 1'b1;
`ifdef MULT_OVF_DETECT_EN
            exc_d    = ovf;
`endif
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
    end
  end

`ifdef MULT_OVF_DETECT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) exc_q <= 1'b0;
    else       exc_q <= exc_d;
  end

  assign bus.data_exception = exc_q;
`else
  assign bus.data_exception = 1'b0;
`endif

  assign bus.data_result    = result_q;
  assign bus.data_resultRdy = rdy_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: an arithmetic reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_shift_add_mult;

  logic clock;
  logic reset;
  int   nChecks;
  int   nPass;
  bit   compareEn;

  shift_add_mult_if bus ();

  shift_add_mult dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef MULT_OVF_DETECT_EN
  localparam logic [31:0] OVF_EXP = 32'd1;
`else
  localparam logic [31:0] OVF_EXP = 32'd0;
`endif

  function automatic logic [31:0] prodLow(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return p[31:0];
  endfunction

  function automatic logic prodOvf(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
`ifdef MULT_OVF_DETECT_EN
    return (p > 64'sd2147483647) || (p < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: a product appears exactly 32 edges after the last accepted start.
  logic        mBusy;
  int          mLeft;
  logic [31:0] mA, mB;
  logic        mRdy;
  logic [31:0] mRes;
  logic        mExc;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mBusy <= 1'b0;
      mLeft <= 0;
      mRdy  <= 1'b0;
      mRes  <= '0;
      mExc  <= 1'b0;
    end else begin
      mRdy <= 1'b0;
      if (bus.ctrl_mult) begin
        mBusy <= 1'b1;
        mLeft <= 32;
        mA    <= bus.data_operandA;
        mB    <= bus.data_operandB;
      end else if (mBusy) begin
        if (mLeft == 1) begin
          mBusy <= 1'b0;
          mRdy  <= 1'b1;
          mRes  <= prodLow(mA, mB);
          mExc  <= prodOvf(mA, mB);
        end
        mLeft <= mLeft - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (compareEn) begin
      checkOutput("cyc rdy", {31'd0, bus.data_resultRdy}, {31'd0, mRdy});
      checkOutput("cyc result", bus.data_result, mRes);
      checkOutput("cyc exception", {31'd0, bus.data_exception}, {31'd0, mExc});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Start pulse sampled on the next edge; operands then scrambled to prove they are ignored.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_mult     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_mult     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic waitResult(output int lat);
    lat = 999;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRdy) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input logic [31:0] expExc);
    int lat;
    applyStimulus(a, b);
    waitResult(lat);
    checkOutput({name, " latency"}, lat, 32);
    checkOutput({name, " result"}, bus.data_result, expRes);
    checkOutput({name, " exception"}, {31'd0, bus.data_exception}, expExc);
  endtask

  initial begin
    int lat;
    int rdySeen;
    nChecks           = 0;
    nPass             = 0;
    compareEn         = 1'b0;
    reset             = 1'b0;
    bus.ctrl_mult     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    #1;
    reset     = 1'b1;
    compareEn = 1'b1;
    idle(3);
    reset = 1'b0;
    checkOutput("reset result", bus.data_result, 32'h0);
    checkOutput("reset rdy", {31'd0, bus.data_resultRdy}, 32'h0);
    checkOutput("reset exception", {31'd0, bus.data_exception}, 32'h0);

    runOp("3x4", 32'd3, 32'd4, 32'h0000000C, 32'd0);
    idle(2);
    runOp("m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'd0);
    idle(1);
    runOp("max x2", 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, OVF_EXP);
    runOp("min x m1 restart in DONE", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, OVF_EXP);
    idle(2);
    runOp("m3x5", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'd0);
    idle(2);

    applyStimulus(32'd5, 32'd7);
    idle(9);
    applyStimulus(32'd6, 32'd9);
    waitResult(lat);
    checkOutput("abort latency", lat, 32);
    checkOutput("abort result", bus.data_result, 32'h00000036);
    idle(2);

    applyStimulus(32'd5, 32'd7);
    idle(14);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrun reset result", bus.data_result, 32'h0);
    checkOutput("midrun reset rdy", {31'd0, bus.data_resultRdy}, 32'h0);
    checkOutput("midrun reset exception", {31'd0, bus.data_exception}, 32'h0);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    rdySeen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRdy) rdySeen++;
    end
    checkOutput("no rdy after reset", rdySeen, 32'd0);

    runOp("2x3 after reset", 32'd2, 32'd3, 32'h00000006, 32'd0);
    idle(2);
    compareEn = 1'b0;
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameters SHALL be none; operand width fixed at 32, iteration count fixed at 32.
REQ-002 clock  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ctrl_mult  input  1  start pulse, sampled on rising edge of clock.
REQ-005 data_operandA  input  32  multiplicand, two's complement.
REQ-006 data_operandB  input  32  multiplier, two's complement.
REQ-007 data_result  output  32  low 32 bits of A*B.
REQ-008 data_exception  output  1  signed overflow flag, valid with data_resultRdy.
REQ-009 data_resultRdy  output  1  one-cycle result-valid strobe.

Function
REQ-010 States SHALL be IDLE, RUN, DONE.
- Reset enters IDLE.
- IDLE->RUN on ctrl_mult.
- RUN->DONE after 32 iterations.
- DONE->IDLE after one cycle, or DONE->RUN if ctrl_mult is high.
REQ-011 On the edge sampling ctrl_mult, block SHALL latch A and B, clear accumulator, and set iteration counter to 0.
- Operand inputs are ignored after that edge.
REQ-012 Each RUN edge SHALL examine B_latched[count].
- If set, add (A_latched << count) to accumulator.
- Shifted value comes from a shift-left stage with shift amount = count[4:0].
REQ-013 Iteration count=31 SHALL subtract rather than add (weight -2^31), giving a correct signed product.
REQ-014 Latency: ctrl_mult sampled at edge 0; RUN occupies edges 1..32; data_resultRdy high for exactly the cycle following edge 32, then low.
REQ-015 data_result SHALL hold the last completed product until the next completion or reset.
- It shall not change during RUN.
REQ-016 ctrl_mult asserted during RUN SHALL abort the current operation and restart with newly latched operands.
- Counter returns to 0.
- No data_resultRdy is issued for the aborted operation.
REQ-017 ctrl_mult in the DONE cycle SHALL be accepted.
- data_resultRdy is still asserted for that cycle.
- Next edge enters RUN with new operands.
REQ-018 Accumulator arithmetic SHALL be modulo 2^64 with A sign-extended to 64 bits.
- data_result = accumulator[31:0].
REQ-019 Counter SHALL stop at 31; no wrap into a second pass.

Reset
REQ-020 reset SHALL, asynchronously, force IDLE, counter=0, accumulator=0, data_result=0, data_exception=0, data_resultRdy=0.
REQ-021 reset mid-RUN SHALL discard the operation; no data_resultRdy is issued after reset deasserts until a new ctrl_mult completes.

Configuration
REQ-022 Macro MULT_OVF_DETECT_EN defined: data_exception = 1 when accumulator[63:31] is not all-equal (product outside signed 32-bit range).
- It is registered together with data_result.
REQ-023 Macro MULT_OVF_DETECT_EN undefined: accumulator upper 32 bits and overflow logic SHALL be omitted (32-bit accumulator); data_exception tied 0.
- data_result SHALL be identical in both builds.

Structure
REQ-024 Shared package mult_pkg SHALL hold:
- state encoding constants (IDLE, RUN, DONE);
- MULT_W=32;
- MULT_ITER=32.
REQ-025 Shifter SHALL be the existing 32-bit logical-left shift module, instantiated once as sub-module sll_32.
- in = A_latched, shft_amt = counter.
- Upper-half shifted bits for overflow build come from a 64-bit extension held in this block.

Verification
REQ-026 A=3, B=4, ctrl_mult at edge 0 -> data_resultRdy high only after edge 32, data_result=0x0000000C, data_exception=0.
REQ-027 A=0xFFFFFFFF, B=0xFFFFFFFF -> data_result=0x00000001, data_exception=0.
REQ-028 A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE; data_exception=1 with MULT_OVF_DETECT_EN, 0 without.
REQ-029 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000; data_exception=1 with macro.
REQ-030 Start A=5, B=7; at edge 10 pulse ctrl_mult with A=6, B=9 -> single data_resultRdy after edge 42, data_result=0x00000036.
REQ-031 Start A=5, B=7; assert reset at edge 15 for one cycle -> all outputs 0 immediately; no data_resultRdy for 40 cycles without a new ctrl_mult.
